hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Parametrised load-use hazard and pipeline-freeze controller for the 5-stage pipelined CPU. Sits beside the ID stage.
- Detects a consumer in IF/ID that reads the destination of a load in ID/EX, then holds it for a configurable number of bubble cycles.
- Also arbitrates data-memory wait (freeze) and branch flush, and suppresses false stalls on register 0 and on unused source operands.

Parameters:
- REG_AW, 5: register address width.
- STALL_CYC, 1: bubble cycles inserted per load-use hazard. Legal range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-low.
- ID_EX_MemRead_i  in  1  instruction in ID/EX is a load.
- ID_EX_RDaddr_i  in  REG_AW  load destination register.
- IF_ID_RSaddr_i  in  REG_AW  consumer rs.
- IF_ID_RTaddr_i  in  REG_AW  consumer rt.
- IF_ID_use_rs_i  in  1  consumer actually reads rs.
- IF_ID_use_rt_i  in  1  consumer actually reads rt.
- mem_busy_i  in  1  data memory not ready; whole pipeline must freeze.
- flush_i  in  1  branch taken, resolved in ID.
- select_o  out  1  1 = inject bubble (zero control) into ID/EX.
- PC_write_o  out  1  PC update enable.
- IF_ID_write_o  out  1  IF/ID update enable.
- IF_ID_flush_o  out  1  clear IF/ID.
- freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB.
- stall_cnt_o  out  32  stall-cycle performance counter (see Optional Feature).

Behaviour:
- Hazard term:
  - hz = ID_EX_MemRead_i && ID_EX_RDaddr_i != 0 && ((use_rs && rs == rd) || (use_rt && rt == rd)).
  - hz is combinational; the first bubble is asserted in the same cycle hz is seen, with zero latency.
- FSM states IDLE and HOLD. Down-counter cnt is 4 bits.
- IDLE:
  - If hz and !mem_busy_i: assert select_o = 1, PC_write_o = 0, IF_ID_write_o = 0.
  - On that same edge: if STALL_CYC > 1, cnt <= STALL_CYC - 1 and go to HOLD; otherwise stay in IDLE.
- HOLD:
  - select_o = 1, PC_write_o = 0, IF_ID_write_o = 0 every cycle.
  - cnt decrements on each edge without mem_busy_i.
  - When cnt == 1 and it decrements, return to IDLE.
  - Total bubbles per hazard = STALL_CYC exactly, independent of ID_EX_MemRead_i (it is 0 during the bubbles).
- Freeze (mem_busy_i = 1), highest priority:
  - freeze_o = 1, PC_write_o = 0, IF_ID_write_o = 0, select_o = 0, IF_ID_flush_o = 0.
  - State and cnt hold. A hazard seen while frozen is acted on in the first unfrozen cycle.
- Flush:
  - IF_ID_flush_o = flush_i && !stall && !mem_busy_i, where stall = (IDLE && hz) || HOLD.
  - While stalled, the branch is still in ID and is re-resolved once the stall ends, so the flush is suppressed.
- No hazard, no freeze: select_o = 0, PC_write_o = 1, IF_ID_write_o = 1, freeze_o = 0.
- Reset (rst_i = 0 at a clock edge):
  - state <= IDLE, cnt <= 0, stall_cnt_o <= 0.
  - Reset mid-HOLD abandons the stall.
  - While rst_i is low, all outputs are forced: select_o 0, PC_write_o 1, IF_ID_write_o 1, IF_ID_flush_o 0, freeze_o 0.
- Back-to-back: a new hazard detected in the IDLE cycle immediately after HOLD starts a fresh stall with no gap cycle.

Optional Feature:
- HAZARD_PERF_EN defined:
  - stall_cnt_o increments by 1 on every clock edge where select_o = 1 or freeze_o = 1.
  - It saturates at 32'hFFFFFFFF and is cleared by reset.
- Not defined: stall_cnt_o is constant 0 and no counter register is built.

Test Plan:
- STALL_CYC = 1. Load to r5 in ID/EX; consumer has rs = 5, use_rs = 1 → one cycle with select_o = 1, PC_write_o = 0, IF_ID_write_o = 0, then back to 1/1 with select_o = 0.
- STALL_CYC = 3, same hazard → select_o high for exactly 3 consecutive cycles, then low.
- False-stall checks:
  - rd = 0 with rs = 0 → no stall.
  - rd = 7, rt = 7, use_rt = 0 → no stall.
- STALL_CYC = 3. Raise mem_busy_i for 2 cycles during the second bubble → freeze_o = 1 for those 2 cycles with select_o = 0; bubbles total 3; stall ends 2 cycles later than without the freeze.
- flush_i = 1 together with a hazard → IF_ID_flush_o = 0. flush_i = 1 with no hazard → IF_ID_flush_o = 1 in the same cycle.
- Drive rst_i low during HOLD (STALL_CYC = 3) → next cycle is IDLE with PC_write_o = 1. With HAZARD_PERF_EN defined, after 4 stall cycles stall_cnt_o = 4, and reset clears it to 0.

Source files
------------

// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Load-use hazard stall, memory-wait freeze and branch-flush
//               control beside the ID stage. HAZARD_PERF_EN adds a stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_unit #(
    parameter int REG_AW    = 5,
    parameter int STALL_CYC = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ID_EX_MemRead_i,
    input  logic [REG_AW-1:0] ID_EX_RDaddr_i,
    input  logic [REG_AW-1:0] IF_ID_RSaddr_i,
    input  logic [REG_AW-1:0] IF_ID_RTaddr_i,
    input  logic              IF_ID_use_rs_i,
    input  logic              IF_ID_use_rt_i,
    input  logic              mem_busy_i,
    input  logic              flush_i,
    output logic              select_o,
    output logic              PC_write_o,
    output logic              IF_ID_write_o,
    output logic              IF_ID_flush_o,
    output logic              freeze_o,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [3:0] C_CNT_LOAD = 4'(STALL_CYC - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic       w_hz;
    logic       w_stall;

    // Register 0 never carries a real dependency, and unused operands never stall.
    assign w_hz = ID_EX_MemRead_i && (ID_EX_RDaddr_i != '0) &&
                  ((IF_ID_use_rs_i && (IF_ID_RSaddr_i == ID_EX_RDaddr_i)) ||
                   (IF_ID_use_rt_i && (IF_ID_RTaddr_i == ID_EX_RDaddr_i)));

    assign w_stall = ((r_state == S_IDLE) && w_hz) || (r_state == S_HOLD);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        select_o      = 1'b0;
        PC_write_o    = 1'b1;
        IF_ID_write_o = 1'b1;
        IF_ID_flush_o = 1'b0;
        freeze_o      = 1'b0;
        if (rst_i && mem_busy_i) begin
            // Freeze holds state and counter; a pending hazard waits for release.
            freeze_o      = 1'b1;
            PC_write_o    = 1'b0;
            IF_ID_write_o = 1'b0;
        end else if (rst_i) begin
            select_o      = w_stall;
            PC_write_o    = !w_stall;
            IF_ID_write_o = !w_stall;
            IF_ID_flush_o = flush_i && !w_stall;
            case (r_state)
                S_IDLE: begin
                    if (w_hz && (STALL_CYC > 1)) begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = C_CNT_LOAD;
                    end
                end
                S_HOLD: begin
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
        end else if ((select_o || freeze_o) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// Bench for hazard_stall_unit: STALL_CYC=1 and STALL_CYC=3 instances share stimulus
// and are checked against a bubbles-remaining reference model.
module tb_hazard_stall_unit;

`ifdef HAZARD_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_i;
    logic        mem_read;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        use_rs;
    logic        use_rt;
    logic        mem_busy;
    logic        flush;
    logic        sel1, pcw1, ifw1, fl1, fz1;
    logic        sel3, pcw3, ifw3, fl3, fz3;
    logic [31:0] cnt1;
    logic [31:0] cnt3;
    logic [9:0]  ctl_obs;
    logic [63:0] cnt_obs;

    int     vectors     = 0;
    int     miscompares = 0;
    int     bl1         = 0;
    int     bl3         = 0;
    longint pc1         = 0;
    longint pc3         = 0;

    assign ctl_obs = {sel1, pcw1, ifw1, fl1, fz1, sel3, pcw3, ifw3, fl3, fz3};
    assign cnt_obs = {cnt1, cnt3};

    hazard_stall_unit #(.REG_AW(5), .STALL_CYC(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_i), .ID_EX_MemRead_i(mem_read), .ID_EX_RDaddr_i(rd),
        .IF_ID_RSaddr_i(rs), .IF_ID_RTaddr_i(rt), .IF_ID_use_rs_i(use_rs),
        .IF_ID_use_rt_i(use_rt), .mem_busy_i(mem_busy), .flush_i(flush),
        .select_o(sel1), .PC_write_o(pcw1), .IF_ID_write_o(ifw1),
        .IF_ID_flush_o(fl1), .freeze_o(fz1), .stall_cnt_o(cnt1)
    );

    hazard_stall_unit #(.REG_AW(5), .STALL_CYC(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_i), .ID_EX_MemRead_i(mem_read), .ID_EX_RDaddr_i(rd),
        .IF_ID_RSaddr_i(rs), .IF_ID_RTaddr_i(rt), .IF_ID_use_rs_i(use_rs),
        .IF_ID_use_rt_i(use_rt), .mem_busy_i(mem_busy), .flush_i(flush),
        .select_o(sel3), .PC_write_o(pcw3), .IF_ID_write_o(ifw3),
        .IF_ID_flush_o(fl3), .freeze_o(fz3), .stall_cnt_o(cnt3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: bl = bubbles still owed after the current cycle.
    function automatic logic hz_f();
        return mem_read && (rd != 5'd0) &&
               ((use_rs && (rs == rd)) || (use_rt && (rt == rd)));
    endfunction

    function automatic logic [4:0] exp_f(input int bl);
        logic stalling;
        if (!rst_i)   return 5'b01100;
        if (mem_busy) return 5'b00001;
        stalling = (bl > 0) || hz_f();
        return {stalling, !stalling, !stalling, flush && !stalling, 1'b0};
    endfunction

    function automatic int nxt_bl(input int bl, input int n);
        if (bl > 0)  return bl - 1;
        if (hz_f())  return n - 1;
        return bl;
    endfunction

    function automatic logic [9:0] exp_ctl();
        return {exp_f(bl1), exp_f(bl3)};
    endfunction

    function automatic logic [63:0] exp_cnt();
        return {(PERF_EN ? pc1[31:0] : 32'd0), (PERF_EN ? pc3[31:0] : 32'd0)};
    endfunction

    task automatic cycle();
        logic [4:0] e1;
        logic [4:0] e3;
        int         n1;
        int         n3;
        e1 = exp_f(bl1);
        e3 = exp_f(bl3);
        n1 = nxt_bl(bl1, 1);
        n3 = nxt_bl(bl3, 3);
        if (!rst_i) begin
            bl1 = 0; bl3 = 0; pc1 = 0; pc3 = 0;
        end else begin
            if (e1[4] || e1[0]) pc1++;
            if (e3[4] || e3[0]) pc3++;
            if (!mem_busy) begin
                bl1 = n1;
                bl3 = n3;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic mr, input logic [4:0] d, input logic [4:0] s,
                          input logic [4:0] t, input logic urs, input logic urt,
                          input logic busy, input logic fl);
        mem_read = mr; rd = d; rs = s; rt = t;
        use_rs = urs; use_rt = urt; mem_busy = busy; flush = fl;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        set_in(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        cycle();
        cycle();
        #4;
        vectors++;
        if (ctl_obs !== 10'b01100_01100) begin
            miscompares++;
            $display("FAIL reset_forced ctl got %b exp %b", ctl_obs, 10'b01100_01100);
        end
        vectors++;
        if (cnt_obs !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_cnt got %h exp 0", cnt_obs);
        end
        cycle();
        rst_i = 1'b1;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        #4;
        vectors++;
        if (ctl_obs !== 10'b01100_01100) begin
            miscompares++;
            $display("FAIL reset_idle ctl got %b exp %b", ctl_obs, 10'b01100_01100);
        end
        cycle();
    endtask

    task automatic test_load_use();
        int n1 = 0;
        int n3 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) set_in(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
            else        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
            #4;
            vectors++;
            if (ctl_obs !== exp_ctl()) begin
                miscompares++;
                $display("FAIL load_use cyc%0d ctl got %b exp %b", i, ctl_obs, exp_ctl());
            end
            if (sel1) n1++;
            if (sel3) n3++;
            cycle();
        end
        vectors++;
        if (n1 !== 1 || n3 !== 3) begin
            miscompares++;
            $display("FAIL load_use_bubbles got %0d/%0d exp 1/3", n1, n3);
        end
    endtask

    task automatic test_false_stall();
        for (int i = 0; i < 2; i++) begin
            if (i == 0) set_in(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
            else        set_in(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
            #4;
            vectors++;
            if (ctl_obs !== 10'b01100_01100) begin
                miscompares++;
                $display("FAIL false_stall%0d ctl got %b exp %b", i, ctl_obs, 10'b01100_01100);
            end
            cycle();
        end
    endtask

    task automatic test_freeze();
        int nsel = 0;
        int nfz  = 0;
        int last = -1;
        for (int i = 0; i < 8; i++) begin
            set_in(i == 0, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0, (i == 1) || (i == 2), 1'b0);
            #4;
            vectors++;
            if (ctl_obs !== exp_ctl()) begin
                miscompares++;
                $display("FAIL freeze cyc%0d ctl got %b exp %b", i, ctl_obs, exp_ctl());
            end
            if (sel3) begin nsel++; last = i; end
            if (fz3)  nfz++;
            cycle();
        end
        vectors++;
        if (nsel !== 3 || nfz !== 2 || last !== 4) begin
            miscompares++;
            $display("FAIL freeze_shape got sel=%0d fz=%0d last=%0d exp 3/2/4", nsel, nfz, last);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 6; i++) begin
            set_in(i == 0, 5'd9, 5'd0, 5'd9, 1'b0, 1'b1, i == 5, i != 3);
            #4;
            vectors++;
            if (ctl_obs !== exp_ctl()) begin
                miscompares++;
                $display("FAIL flush cyc%0d ctl got %b exp %b", i, ctl_obs, exp_ctl());
            end
            if (i == 0) begin
                vectors++;
                if ({fl1, fl3} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL flush_hazard got %b exp 00", {fl1, fl3});
                end
            end
            if (i == 4) begin
                vectors++;
                if ({fl1, fl3} !== 2'b11) begin
                    miscompares++;
                    $display("FAIL flush_plain got %b exp 11", {fl1, fl3});
                end
            end
            cycle();
        end
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 8; i++) begin
            rst_i = !((i == 0) || (i == 6));
            set_in((i == 1) || (i == 5), 5'd4, 5'd4, 5'd0, 1'b1, 1'b0, i == 4, 1'b0);
            #4;
            vectors++;
            if (ctl_obs !== exp_ctl()) begin
                miscompares++;
                $display("FAIL rst_hold cyc%0d ctl got %b exp %b", i, ctl_obs, exp_ctl());
            end
            vectors++;
            if (cnt_obs !== exp_cnt()) begin
                miscompares++;
                $display("FAIL rst_hold_cnt cyc%0d got %h exp %h", i, cnt_obs, exp_cnt());
            end
            if (i == 5) begin
                vectors++;
                if (cnt3 !== (PERF_EN ? 32'd4 : 32'd0) || cnt1 !== (PERF_EN ? 32'd2 : 32'd0)) begin
                    miscompares++;
                    $display("FAIL perf_count got %0d/%0d", cnt1, cnt3);
                end
            end
            if (i == 7) begin
                vectors++;
                if ({pcw3, sel3} !== 2'b10 || cnt3 !== 32'd0) begin
                    miscompares++;
                    $display("FAIL rst_abandon got pcw=%b sel=%b cnt=%0d exp 1 0 0", pcw3, sel3, cnt3);
                end
            end
            cycle();
        end
        rst_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        int n1 = 0;
        int n3 = 0;
        for (int i = 0; i < 11; i++) begin
            set_in(i < 8, 5'd3, 5'd0, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0);
            #4;
            vectors++;
            if (ctl_obs !== exp_ctl()) begin
                miscompares++;
                $display("FAIL b2b cyc%0d ctl got %b exp %b", i, ctl_obs, exp_ctl());
            end
            if (sel1) n1++;
            if (sel3) n3++;
            cycle();
        end
        vectors++;
        if (n1 !== 8 || n3 !== 9) begin
            miscompares++;
            $display("FAIL b2b_bubbles got %0d/%0d exp 8/9", n1, n3);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_i = ($urandom_range(0, 99) >= 3);
            set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
            #4;
            vectors++;
            if (ctl_obs !== exp_ctl()) begin
                miscompares++;
                $display("FAIL random cyc%0d ctl got %b exp %b", i, ctl_obs, exp_ctl());
            end
            vectors++;
            if (cnt_obs !== exp_cnt()) begin
                miscompares++;
                $display("FAIL random_cnt cyc%0d got %h exp %h", i, cnt_obs, exp_cnt());
            end
            cycle();
        end
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i = 1'b0;
        set_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_load_use();
        test_false_stall();
        test_freeze();
        test_flush();
        test_reset_mid_hold();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
